// File: rtl/mem_arbiter.sv
// Shares one byte-addressed data memory between the fetch and load/store ports.
// Handles funct3 lane mapping, load extension and error rejection; responses arrive one cycle after grant.
module mem_arbiter #(
    parameter int unsigned MEM_BYTES  = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [2:0]  d_funct3,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    output logic        store_enable,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);
    localparam logic [2:0]  F3_B  = 3'b000;
    localparam logic [2:0]  F3_H  = 3'b001;
    localparam logic [2:0]  F3_W  = 3'b010;
    localparam logic [2:0]  F3_BU = 3'b100;
    localparam logic [2:0]  F3_HU = 3'b101;

    typedef enum logic {
        LAST_F = 1'b0,
        LAST_D = 1'b1
    } grant_e;

    grant_e      state;
    grant_e      state_nxt;
    logic        if_err_c;
    logic        d_err_c;
    logic [31:0] shifted_c;
    logic [31:0] load_ext_c;

    // Arbiter state register: remembers which port was granted last
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= LAST_F;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (d_gnt) begin
            state_nxt = LAST_D;
        end else if (if_gnt) begin
            state_nxt = LAST_F;
        end
    end

    // Grants: a lone requester wins; on contention round-robin or data-first
    always_comb begin
        if_gnt = 1'b0;
        d_gnt  = 1'b0;
        if (reset_n) begin
            if (d_req && !if_req) begin
                d_gnt = 1'b1;
            end else if (if_req && !d_req) begin
                if_gnt = 1'b1;
            end else if (if_req && d_req) begin
                if (FIXED_PRIO || (state == LAST_F)) begin
                    d_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if_err_c = (|if_addr[1:0]) || (if_addr >= ADDR_LIMIT);
    end

    always_comb begin
        d_err_c = 1'b0;
        case (d_funct3)
            F3_B:    d_err_c = 1'b0;
            F3_H:    d_err_c = d_addr[0];
            F3_W:    d_err_c = |d_addr[1:0];
            F3_BU:   d_err_c = d_we;
            F3_HU:   d_err_c = d_we || d_addr[0];
            default: d_err_c = 1'b1;
        endcase
        if (d_addr >= ADDR_LIMIT) begin
            d_err_c = 1'b1;
        end
    end

    // Memory-side drive: only the granted port reaches the memory, errors never write
    always_comb begin
        mem_address      = '0;
        mem_write_data   = '0;
        mem_write_enable = '0;
        store_enable     = 1'b0;
        if (d_gnt) begin
            mem_address = d_addr;
            if (d_we && !d_err_c) begin
                store_enable = 1'b1;
                case (d_funct3)
                    F3_B: begin
                        mem_write_enable = 4'b0001 << d_addr[1:0];
                        mem_write_data   = {4{d_wdata[7:0]}};
                    end
                    F3_H: begin
                        mem_write_enable = 4'b0011 << d_addr[1:0];
                        mem_write_data   = {2{d_wdata[15:0]}};
                    end
                    default: begin
                        mem_write_enable = 4'b1111;
                        mem_write_data   = d_wdata;
                    end
                endcase
            end
        end else if (if_gnt) begin
            mem_address = if_addr;
        end
    end

    always_comb begin
        shifted_c  = mem_read_data >> {d_addr[1:0], 3'b000};
        load_ext_c = shifted_c;
        case (d_funct3)
            F3_B:    load_ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            F3_BU:   load_ext_c = {24'h0, shifted_c[7:0]};
            F3_H:    load_ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            F3_HU:   load_ext_c = {16'h0, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
    end

    // Response registers: one-cycle pulse after each grant
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            if_err    <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            d_err     <= 1'b0;
        end else begin
            if_rvalid <= if_gnt;
            if_err    <= if_gnt && if_err_c;
            if_rdata  <= (if_gnt && !if_err_c) ? mem_read_data : '0;
            d_rvalid  <= d_gnt;
            d_err     <= d_gnt && d_err_c;
            d_rdata   <= (d_gnt && !d_err_c && !d_we) ? load_ext_c : '0;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single byte-addressed data memory between the instruction-fetch port and the load/store port, issuing at most one access per cycle. Converts RISC-V load/store size codes (funct3) into byte-lane write enables, replicated write data and sign/zero-extended read data. Misaligned and out-of-range requests are rejected with an error response instead of touching memory. The block sits between the core's fetch and LSU stages and the memory module; it owns that module's address, write data, write enable and store enable inputs.

## Interface
- MEM_BYTES, 256: memory size in bytes; any address >= MEM_BYTES is out of range.
- FIXED_PRIO, 0: 0 = round-robin between ports; 1 = data port always wins.

- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch response valid (registered)
- if_rdata  out  32  fetched word
- if_err  out  1  fetch error, valid with if_rvalid
- d_req  in  1  data request; held with d_we, d_funct3, d_addr, d_wdata until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- d_addr  in  32  data byte address
- d_wdata  in  32  store data, right-aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data response valid (registered); pulses for loads and stores
- d_rdata  out  32  extended load data; 0 for stores and errors
- d_err  out  1  misaligned, out-of-range or illegal funct3; valid with d_rvalid
- mem_address  out  32  to memory `address`
- mem_write_data  out  32  to memory `mem_write_data`
- mem_write_enable  out  4  to memory `mem_write_enable`
- store_enable  out  1  to memory `store_enable`
- mem_read_data  in  32  from memory, combinational word read at {addr[7:2],00}

## Operation
- Arbiter state: a one-bit last_grant register with states LAST_F and LAST_D. Reset state is LAST_F, so the data port wins the first contention.
- Arbitration rules:
  - Only one requester active: that requester is granted.
  - Both active, FIXED_PRIO=0: grant the port not recorded in last_grant.
  - Both active, FIXED_PRIO=1: always grant the data port.
- last_grant updates only on a grant. Rejected requests still count as grants.
- Error checks:
  - Fetch: error if if_addr[1:0] != 0 or the address is out of range.
  - Data: error if H/HU with addr[0] = 1, W with addr[1:0] != 0, funct3 is 011/110/111, BU/HU with d_we = 1, or the address is out of range.
- A rejected request is still granted. It drives store_enable = 0 and mem_write_enable = 0, and its response carries err = 1 and rdata = 0.
- Store lane mapping (off = addr[1:0]):
  - B: we = 0001 << off; write data = byte replicated to all 4 lanes.
  - H: we = 0011 << off; write data = {h, h}.
  - W: we = 1111; write data = d_wdata.
  - store_enable = 1 only for a granted, error-free store.
- Load extraction: shift mem_read_data right by 8*off, then:
  - B: sign-extend bits [7:0].
  - BU: zero-extend bits [7:0].
  - H: sign-extend bits [15:0].
  - HU: zero-extend bits [15:0].
  - W: pass through.
- Fetch returns mem_read_data unmodified.
- Memory outputs with no grant: mem_address = 0, mem_write_data = 0, mem_write_enable = 0, store_enable = 0.

## Timing
- Cycle N, request granted:
  - mem_address is driven from the granted port.
  - For a store, the write commits at the N→N+1 edge.
  - Load or fetch data is extracted combinationally and registered at the same edge.
- Cycle N+1: rvalid/rdata/err are presented for exactly one cycle. Latency is 1 and throughput is 1 access per cycle.
- Back-to-back: a new request may be granted in N+1 while the N response is presented.
- A load in N+1 to an address stored in N returns the new data.
- Requesters must not change their request fields while req is high and gnt is low. A requester that drops req before gnt gets no response.
- While reset_n is low:
  - if_gnt, d_gnt, store_enable and mem_write_enable are forced to 0.
  - All registered outputs are 0: if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err.
  - last_grant = LAST_F.
- Reset asserted after a grant and before the response: the response is discarded; no rvalid appears after reset releases.
- Reset asserted in the same cycle as a store grant: the write does not occur.

## Test plan
- Reset: reset_n low for 3 cycles with if_req = d_req = 1 and a store pending → both gnts 0, store_enable 0, all rvalids 0. After release, the first contention grants data.
- Word and sub-word access:
  - SW 0x12345678 @0x10, then LW @0x10 → d_rdata = 0x12345678 one cycle after grant.
  - LB @0x13 → 0x00000012.
  - LHU @0x12 → 0x00001234.
- Sign extension: SB 0x80 @0x11 (we = 0010, write data = 0x80808080), then LB @0x11 → 0xFFFFFF80 and LBU @0x11 → 0x00000080.
- Errors:
  - SH @0x13 → d_gnt = 1, store_enable stays 0, next cycle d_rvalid = 1, d_err = 1, d_rdata = 0; an LW @0x10 afterwards shows memory unchanged.
  - if_addr = 0x102 with MEM_BYTES = 256 → if_err = 1.
- Round-robin (FIXED_PRIO=0): if_req and d_req both held high for 4 cycles with fresh addresses → grant sequence D, F, D, F, each followed one cycle later by the matching rvalid.
- Fixed priority and mid-op reset:
  - FIXED_PRIO=1, d_req high for 3 cycles → if_gnt stays 0, then asserts in the cycle d_req drops.
  - reset_n pulsed low the cycle after an LW grant → no d_rvalid is observed.
